// File: rtl/finv_issue_arbiter_if.sv
// rtl/finv_issue_arbiter_if.sv - request/response bundle between FP issue logic and the finv arbiter
//
// Purpose: groups the requester handshake and the tagged result return.
// Signals:
//   req_valid [N_REQ]     request pending, one bit per requester
//   req_data  [32*N_REQ]  single-precision operand, slot i = [32*i +: 32]
//   req_ready [N_REQ]     one-hot grant
//   rsp_valid             one-cycle result pulse, no backpressure
//   rsp_id    [ID_W]      requester that issued the result
//   rsp_data  [32]        1.0/src
//   rsp_ovf / rsp_udf     finv flags for the result
// Modports: master = requester side, slave = arbiter side.
interface finv_issue_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_data;
  logic                rsp_ovf;
  logic                rsp_udf;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_udf
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_udf
  );
endinterface

// File: rtl/finv_issue_arbiter.sv
// rtl/finv_issue_arbiter.sv - round-robin issue arbiter sharing one pipelined finv unit
//
// Purpose: picks one requester per cycle by round-robin, registers its operand
// into the finv source register, carries {valid,id} alongside the operand and
// returns the finv result tagged with the id. Handshake to rsp_valid is
// 1+FINV_LAT cycles; throughput one op per cycle; results in issue order.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   arb          finv_issue_arbiter_if.slave (requests in, tagged results out)
//   busy         any operation in flight
//   sticky_clr   (FINV_ARB_STICKY_EN only) per-requester clear
//   sticky_ovf   (FINV_ARB_STICKY_EN only) per-requester accumulated ovf
//   sticky_udf   (FINV_ARB_STICKY_EN only) per-requester accumulated udf
// Build option: define FINV_ARB_STICKY_EN to add the sticky flag vectors.
//
// finv: reciprocal unit. FINV_LAT-1 internal stages after the source register.
// Zero/denormal input -> signed inf with ovf; inf -> signed zero; NaN -> qNaN;
// quotient truncated; results below the normal range flush to signed zero with udf.
module finv #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_i,
  output logic [31:0] dest_o,
  output logic        ovf_o,
  output logic        udf_o
);
  logic              s;
  logic [7:0]        e;
  logic [22:0]       f;
  logic [24:0]       q;
  logic signed [9:0] ex;
  logic [33:0]       res_c;
  logic [33:0]       stg_q [LAT-1];

  assign s = src_i[31];
  assign e = src_i[30:23];
  assign f = src_i[22:0];

  // 2/(1.f) scaled to 23 fraction bits; only f==0 gives exactly 2^24.
  assign q  = 25'(48'h8000_0000_0000 / {24'd0, 1'b1, f});
  assign ex = 10'sd254 - $signed({2'b00, e}) - (q[24] ? 10'sd0 : 10'sd1);

  always_comb begin
    res_c = '0;
    if (e == 8'hFF)
      res_c = (f != '0) ? {2'b00, 32'h7FC0_0000} : {2'b00, s, 31'd0};
    else if (e == 8'h00)
      res_c = {2'b10, s, 8'hFF, 23'd0};
    else if (ex <= 10'sd0)
      res_c = {2'b01, s, 31'd0};
    else
      res_c = {2'b00, s, ex[7:0], (q[24] ? q[23:1] : q[22:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT-1; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= res_c;
      for (int i = 1; i < LAT-1; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign {ovf_o, udf_o, dest_o} = stg_q[LAT-2];
endmodule

module finv_issue_arbiter #(
  parameter int N_REQ    = 4,
  parameter int FINV_LAT = 2,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic clk,
  input  logic rst,
  finv_issue_arbiter_if.slave arb,
  output logic busy
`ifdef FINV_ARB_STICKY_EN
  ,
  input  logic [N_REQ-1:0] sticky_clr,
  output logic [N_REQ-1:0] sticky_ovf,
  output logic [N_REQ-1:0] sticky_udf
`endif
);
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  idx;
  logic             hs;
  logic [31:0]      op_sel;
  logic [31:0]      src_q;
  tag_t             tag_q [FINV_LAT+1];
  logic [31:0]      rsp_data_q;
  logic             rsp_ovf_q, rsp_udf_q;
  logic [31:0]      fdest;
  logic             fovf, fudf;

  // Scan from ptr upward, wrapping; first valid requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    sum      = '0;
    idx      = '0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
        idx = sum[ID_W-1:0];
        if (grant == '0 && arb.req_valid[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = idx;
        end
      end
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) op_sel = arb.req_data[32*i +: 32];
  end

  // Grant is only ever given to a valid requester, so any grant is a handshake.
  assign hs    = |grant;
  assign ptr_d = !hs ? ptr_q :
                 (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      src_q      <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_udf_q  <= 1'b0;
      for (int i = 0; i <= FINV_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (hs) src_q <= op_sel;
      tag_q[0] <= '{vld: hs, id: grant_id};
      for (int i = 1; i <= FINV_LAT; i++) tag_q[i] <= tag_q[i-1];
      // finv dest lines up with the stage before the last one; capturing here
      // makes data and rsp_valid appear in the same cycle.
      if (tag_q[FINV_LAT-1].vld) begin
        rsp_data_q <= fdest;
        rsp_ovf_q  <= fovf;
        rsp_udf_q  <= fudf;
      end
    end
  end

  finv #(.LAT(FINV_LAT)) u_finv (
    .clk    (clk),
    .rst    (rst),
    .src_i  (src_q),
    .dest_o (fdest),
    .ovf_o  (fovf),
    .udf_o  (fudf)
  );

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= FINV_LAT; i++) busy = busy | tag_q[i].vld;
  end

  assign arb.req_ready = grant;
  assign arb.rsp_valid = tag_q[FINV_LAT].vld;
  assign arb.rsp_id    = tag_q[FINV_LAT].id;
  assign arb.rsp_data  = rsp_data_q;
  assign arb.rsp_ovf   = rsp_ovf_q;
  assign arb.rsp_udf   = rsp_udf_q;

`ifdef FINV_ARB_STICKY_EN
  logic [N_REQ-1:0] sticky_ovf_q, sticky_udf_q;
  logic [N_REQ-1:0] set_ovf, set_udf;

  always_comb begin
    set_ovf = '0;
    set_udf = '0;
    if (arb.rsp_valid && rsp_ovf_q) set_ovf[arb.rsp_id] = 1'b1;
    if (arb.rsp_valid && rsp_udf_q) set_udf[arb.rsp_id] = 1'b1;
  end

  // Set is OR-ed after the clear so a simultaneous set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_q <= '0;
      sticky_udf_q <= '0;
    end else begin
      sticky_ovf_q <= (sticky_ovf_q & ~sticky_clr) | set_ovf;
      sticky_udf_q <= (sticky_udf_q & ~sticky_clr) | set_udf;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_udf = sticky_udf_q;
`endif
endmodule

// File: tb/tb_finv_issue_arbiter.sv
// tb/tb_finv_issue_arbiter.sv - randomized self-checking bench for finv_issue_arbiter
module tb_finv_issue_arbiter;
  localparam int N_REQ    = 4;
  localparam int FINV_LAT = 2;
  localparam int ID_W     = 2;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] d;
    logic        o;
    logic        u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  finv_issue_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) arb ();

`ifdef FINV_ARB_STICKY_EN
  logic [N_REQ-1:0] sticky_clr = '0;
  logic [N_REQ-1:0] sticky_ovf, sticky_udf;
  logic [N_REQ-1:0] st_o_m = '0;
  logic [N_REQ-1:0] st_u_m = '0;
`endif

  finv_issue_arbiter #(.N_REQ(N_REQ), .FINV_LAT(FINV_LAT), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .arb  (arb),
    .busy (busy)
`ifdef FINV_ARB_STICKY_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
    .sticky_udf (sticky_udf)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          ptr_m  = 0;
  exp_t        exp_q[$];
  logic [N_REQ-1:0] pend = '0;
  logic [31:0] pdat [N_REQ];
  logic [31:0] hold_d = '0;
  logic        hold_o = 1'b0;
  logic        hold_u = 1'b0;
  logic        after_rst = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  // Golden reciprocal: real-valued 1.0/x, truncated to single precision.
  function automatic logic [33:0] ref_finv(input logic [31:0] x);
    logic        s;
    int          e;
    int          se;
    real         r;
    logic [63:0] rb;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 255) return (x[22:0] != '0) ? {2'b00, 32'h7FC0_0000} : {2'b00, s, 31'd0};
    if (e == 0) return {2'b10, s, 8'hFF, 23'd0};
    r  = 1.0 / $bitstoreal({s, 11'(e - 127 + 1023), x[22:0], 29'd0});
    rb = $realtobits(r);
    se = int'(rb[62:52]) - 1023 + 127;
    if (se <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, 8'(se), rb[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'hFE - 8'($urandom_range(0, 2));
      default: ;
    endcase
    return v;
  endfunction

  task automatic run_cycle(input logic rst_v);
    int               g;
    logic [N_REQ-1:0] exp_ready;
    logic [N_REQ-1:0] set_o, set_u;
    exp_t             r;
    logic [33:0]      f;
    logic             due;
    @(posedge clk);
    #1;
    rst = rst_v;
    arb.req_valid = pend;
    for (int i = 0; i < N_REQ; i++) arb.req_data[32*i +: 32] = pdat[i];
`ifdef FINV_ARB_STICKY_EN
    sticky_clr = ($urandom_range(0, 3) == 0) ? N_REQ'($urandom) : '0;
`endif
    @(negedge clk);
    g = -1;
    if (!rst_v)
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && pend[(ptr_m + k) % N_REQ]) g = (ptr_m + k) % N_REQ;
    exp_ready = (g >= 0) ? (N_REQ'(1) << g) : '0;
    check("req_ready", 32'(arb.req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    due = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    check("rsp_valid", 32'(arb.rsp_valid), 32'(due));
    set_o = '0;
    set_u = '0;
    if (due) begin
      r = exp_q.pop_front();
      check("rsp_id", 32'(arb.rsp_id), 32'(r.id));
      hold_d = r.d;
      hold_o = r.o;
      hold_u = r.u;
      if (r.o) set_o[r.id] = 1'b1;
      if (r.u) set_u[r.id] = 1'b1;
    end
    if (after_rst) check("rsp_id_after_rst", 32'(arb.rsp_id), 32'd0);
    check("rsp_data", arb.rsp_data, hold_d);
    check("rsp_ovf", 32'(arb.rsp_ovf), 32'(hold_o));
    check("rsp_udf", 32'(arb.rsp_udf), 32'(hold_u));
`ifdef FINV_ARB_STICKY_EN
    check("sticky_ovf", 32'(sticky_ovf), 32'(st_o_m));
    check("sticky_udf", 32'(sticky_udf), 32'(st_u_m));
    st_o_m = (st_o_m & ~sticky_clr) | set_o;
    st_u_m = (st_u_m & ~sticky_clr) | set_u;
`endif
    if (g >= 0) begin
      f = ref_finv(pdat[g]);
      exp_q.push_back('{cyc + 1 + FINV_LAT, g, f[31:0], f[33], f[32]});
      ptr_m   = (g + 1) % N_REQ;
      pend[g] = 1'b0;
    end
    if (rst_v) begin
      exp_q.delete();
      ptr_m  = 0;
      hold_d = '0;
      hold_o = 1'b0;
      hold_u = 1'b0;
`ifdef FINV_ARB_STICKY_EN
      st_o_m = '0;
      st_u_m = '0;
`endif
    end
    after_rst = rst_v;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) pdat[i] = '0;
    arb.req_valid = '0;
    arb.req_data  = '0;
    repeat (2) @(posedge clk);
    run_cycle(1'b0);

    // single request, 2.0 -> 0.5
    pend[0] = 1'b1;
    pdat[0] = 32'h4000_0000;
    repeat (4) run_cycle(1'b0);
    check("t1_rsp_valid", 32'(arb.rsp_valid), 32'd1);
    check("t1_rsp_data", arb.rsp_data, 32'h3F00_0000);
    run_cycle(1'b0);
    run_cycle(1'b1);

    // all four held from the same cycle
    for (int i = 0; i < N_REQ; i++) pdat[i] = rand_op();
    pend = '1;
    repeat (8) run_cycle(1'b0);

    // move ptr to 3, then req3 + req1 wrap, then all valid starts at ptr 2
    pend[2] = 1'b1;
    pdat[2] = rand_op();
    run_cycle(1'b0);
    pend[3] = 1'b1;
    pend[1] = 1'b1;
    pdat[3] = rand_op();
    pdat[1] = rand_op();
    repeat (2) run_cycle(1'b0);
    for (int i = 0; i < N_REQ; i++) pdat[i] = rand_op();
    pend = '1;
    repeat (8) run_cycle(1'b0);

    // reset right after an issue
    pend[2] = 1'b1;
    pdat[2] = rand_op();
    run_cycle(1'b0);
    run_cycle(1'b1);
    repeat (5) run_cycle(1'b0);

    // smallest denormal
    pend[0] = 1'b1;
    pdat[0] = 32'h0000_0001;
    repeat (5) run_cycle(1'b0);

    // random traffic with occasional drops and resets
    repeat (11000) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          pdat[i] = rand_op();
        end
      end
      run_cycle($urandom_range(0, 1999) == 0);
    end
    pend = '0;
    repeat (6) run_cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
